// File: rtl/dgldpc_conv_pkg.sv
// dgldpc_conv_pkg: shared mode encoding and popcount helper for the SM/TC converter
package dgldpc_conv_pkg;
  typedef enum logic {CONV_SM2TC = 1'b0, CONV_TC2SM = 1'b1} conv_mode_e;
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += 32'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/sm_tc_lane.sv
// sm_tc_lane: per-lane SM<->TC arithmetic split into stage-1 and stage-2 combinational halves
//   x                 -> oc, corr, mz   : stage-1 ones'-complement image, +1 correction, magnitude-zero flag
//   mode, oc_q/corr_q/mz_q -> y, sat    : stage-2 final add and saturation select from registered stage 1
module sm_tc_lane
  import dgldpc_conv_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] oc,
  output logic         corr,
  output logic         mz,
  input  conv_mode_e   mode,
  input  logic [W-1:0] oc_q,
  input  logic         corr_q,
  input  logic         mz_q,
  output logic [W-1:0] y,
  output logic         sat
);
  logic [W-2:0] mag;
  assign oc   = {x[W-1], x[W-2:0] ^ {(W-1){x[W-1]}}};
  assign corr = x[W-1];
  assign mz   = ~|x[W-2:0];
  // TC->SM adds the correction only into the magnitude field; the minimum code wraps here and is caught by sat
  assign mag  = oc_q[W-2:0] + (W-1)'(corr_q);
  assign sat  = (mode == CONV_TC2SM) & corr_q & mz_q;
  // SM->TC uses the full-width add, so negative zero wraps cleanly to 0
  assign y    = (mode == CONV_SM2TC) ? oc_q + W'(corr_q) :
                sat ? {W{1'b1}} : {oc_q[W-1], mag};
endmodule

// File: rtl/sm_tc_conv_pipe.sv
// sm_tc_conv_pipe: 2-stage multi-lane bidirectional sign-magnitude/two's-complement converter
//   i_valid/o_ready, i_mode, i_data : input beat (mode 0 = SM->TC, 1 = TC->SM)
//   o_valid/i_ready, o_data, o_sat  : converted beat and per-lane saturation flags
//   i_cnt_clr, o_sat_cnt            : clearable saturating count of delivered saturated lanes
module sm_tc_conv_pipe
  import dgldpc_conv_pkg::*;
#(
  parameter int W     = 6,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_mode,
  input  logic [LANES*W-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [LANES*W-1:0] o_data,
  output logic [LANES-1:0]   o_sat,
  input  logic               i_cnt_clr,
  output logic [CNT_W-1:0]   o_sat_cnt
);
  logic               s1_valid, s2_valid, adv1, adv2;
  conv_mode_e         s1_mode;
  logic [LANES*W-1:0] s1_oc, oc_d, y_d;
  logic [LANES-1:0]   s1_corr, s1_mz, corr_d, mz_d, sat_d;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   cnt_nxt;
  assign adv2    = !s2_valid | i_ready;
  assign adv1    = !s1_valid | adv2;
  assign o_ready = adv1;
  assign o_valid = s2_valid;
  assign cnt_sum = {1'b0, o_sat_cnt} + (CNT_W+1)'(popcount(32'(o_sat)));
  assign cnt_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sm_tc_lane #(.W(W)) u_lane (
      .x     (i_data[k*W +: W]),
      .oc    (oc_d[k*W +: W]),
      .corr  (corr_d[k]),
      .mz    (mz_d[k]),
      .mode  (s1_mode),
      .oc_q  (s1_oc[k*W +: W]),
      .corr_q(s1_corr[k]),
      .mz_q  (s1_mz[k]),
      .y     (y_d[k*W +: W]),
      .sat   (sat_d[k])
    );
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_mode   <= CONV_SM2TC;
      s1_oc     <= '0;
      s1_corr   <= '0;
      s1_mz     <= '0;
      o_data    <= '0;
      o_sat     <= '0;
      o_sat_cnt <= '0;
    end else begin
      if (adv1) s1_valid <= i_valid;
      if (adv1 & i_valid) begin
        s1_mode <= conv_mode_e'(i_mode);
        s1_oc   <= oc_d;
        s1_corr <= corr_d;
        s1_mz   <= mz_d;
      end
      if (adv2) s2_valid <= s1_valid;
      if (adv2 & s1_valid) begin
        o_data <= y_d;
        o_sat  <= sat_d;
      end
      o_sat_cnt <= i_cnt_clr ? '0 : (o_valid & i_ready) ? cnt_nxt : o_sat_cnt;
    end
  end
endmodule

// File: tb/tb_sm_tc_conv_pipe.sv
// tb_sm_tc_conv_pipe: scoreboard bench for sm_tc_conv_pipe (W=6, LANES=4, CNT_W=4)
module tb_sm_tc_conv_pipe;
  localparam int W = 6, L = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    logic [L*W-1:0] d;
    logic [L-1:0]   s;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_mode = 1'b0, i_ready = 1'b1, i_cnt_clr = 1'b0;
  logic o_ready, o_valid;
  logic [L*W-1:0] i_data = '0, o_data;
  logic [L-1:0]   o_sat;
  logic [CW-1:0]  o_sat_cnt;
  int n_chk = 0, n_err = 0, mcnt = 0;
  exp_t q[$];
  exp_t me;
  logic [L*W-1:0] cap[$];
  bit cap_en = 0, prev_stall = 0;
  logic [L*W-1:0] prev_d;
  logic [L-1:0]   prev_s;

  sm_tc_conv_pipe #(.W(W), .LANES(L), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat),
    .i_cnt_clr(i_cnt_clr), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [L*W-1:0] d, input logic m);
    exp_t e;
    logic [W-1:0] x;
    int v;
    e.d = '0;
    e.s = '0;
    for (int k = 0; k < L; k++) begin
      x = d[k*W +: W];
      if (!m) begin
        v = x[W-1] ? -int'(x[W-2:0]) : int'(x[W-2:0]);
        e.d[k*W +: W] = W'(v);
      end else begin
        v = int'($signed(x));
        if (v >= 0) e.d[k*W +: W] = x;
        else if (v == -(1 << (W-1))) begin
          e.d[k*W +: W] = {W{1'b1}};
          e.s[k] = 1'b1;
        end else e.d[k*W +: W] = {1'b1, (W-1)'(-v)};
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      check("cnt", 32'(o_sat_cnt), 32'(mcnt));
      if (prev_stall) begin
        check("hold_v", 32'(o_valid), 1);
        check("hold_d", 32'(o_data), 32'(prev_d));
        check("hold_s", 32'(o_sat), 32'(prev_s));
      end
      prev_stall = o_valid & !i_ready;
      prev_d = o_data;
      prev_s = o_sat;
      if (o_valid & i_ready) begin
        if (q.size() == 0) check("extra_beat", 1, 0);
        else begin
          me = q.pop_front();
          check("data", 32'(o_data), 32'(me.d));
          check("sat", 32'(o_sat), 32'(me.s));
        end
        if (cap_en) cap.push_back(o_data);
      end
      if (i_cnt_clr) mcnt = 0;
      else if (o_valid & i_ready) mcnt = (mcnt + $countones(o_sat) > CMAX) ? CMAX : mcnt + $countones(o_sat);
      if (i_valid & o_ready) q.push_back(model(i_data, i_mode));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [L*W-1:0] d, input logic m);
    bit acc;
    acc = 0;
    i_valid = 1'b1;
    i_data = d;
    i_mode = m;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() != 0; t++) cyc(1);
    check("drain", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [L*W-1:0] d, got;
    logic [L*W-1:0] mid[$];
    int cexp[5];
    int c;
    cexp = '{4, 8, 12, 15, 15};
    #2;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_sat", 32'(o_sat), 0);
    check("rst_cnt", 32'(o_sat_cnt), 0);
    #6 rst_n = 1'b1;
    cyc(2);
    send({6'b011111, 6'b100000, 6'b000111, 6'b100101}, 1'b0);
    check("t1_early", 32'(o_valid), 0);
    cyc(1);
    check("t1_lat", 32'(o_valid), 1);
    check("t1_data", 32'(o_data), 32'({6'b011111, 6'b000000, 6'b000111, 6'b111011}));
    check("t1_sat", 32'(o_sat), 0);
    drain();
    send({6'b100001, 6'b000000, 6'b100000, 6'b111011}, 1'b1);
    check("t2_early", 32'(o_valid), 0);
    cyc(1);
    check("t2_lat", 32'(o_valid), 1);
    check("t2_data", 32'(o_data), 32'({6'b111111, 6'b000000, 6'b111111, 6'b100101}));
    check("t2_sat", 32'(o_sat), 32'(4'b0010));
    cyc(1);
    check("t2_cnt", 32'(o_sat_cnt), 1);
    drain();
    fork
      begin
        for (int b = 0; b < 10; b++) send(24'($urandom), b[0]);
      end
      begin
        cyc(4);
        i_ready = 1'b0;
        cyc(4);
        check("stall_ready", 32'(o_ready), 0);
        cyc(1);
        i_ready = 1'b1;
      end
    join
    drain();
    cap.delete();
    cap_en = 1;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < L; k++) d[k*W +: W] = W'(b*L + k);
      send(d, 1'b1);
    end
    drain();
    cap_en = 0;
    check("rt_count1", cap.size(), 16);
    mid = cap;
    cap.delete();
    cap_en = 1;
    foreach (mid[i]) send(mid[i], 1'b0);
    drain();
    cap_en = 0;
    check("rt_count2", cap.size(), 16);
    for (int b = 0; b < 16 && b < cap.size(); b++) begin
      got = cap[b];
      for (int k = 0; k < L; k++) begin
        c = b*L + k;
        check("round_trip", 32'(got[k*W +: W]), (c == 32) ? 33 : c);
      end
    end
    i_cnt_clr = 1'b1;
    cyc(1);
    i_cnt_clr = 1'b0;
    check("cnt_clr0", 32'(o_sat_cnt), 0);
    for (int j = 0; j < 5; j++) begin
      send({L{6'b100000}}, 1'b1);
      cyc(3);
      check("cnt_clamp", 32'(o_sat_cnt), 32'(cexp[j]));
    end
    send({L{6'b100000}}, 1'b1);
    for (int t = 0; t < 10 && !o_valid; t++) cyc(1);
    check("clr_xfer_v", 32'(o_valid), 1);
    i_cnt_clr = 1'b1;
    cyc(1);
    i_cnt_clr = 1'b0;
    check("clr_xfer", 32'(o_sat_cnt), 0);
    drain();
    send({L{6'b100000}}, 1'b1);
    drain();
    cyc(2);
    check("pre_rst_cnt", 32'(o_sat_cnt), 4);
    i_ready = 1'b0;
    send({L{6'b100000}}, 1'b1);
    send({6'b100011, 6'b010101, 6'b111111, 6'b000001}, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_data", 32'(o_data), 0);
    check("mid_rst_sat", 32'(o_sat), 0);
    check("mid_rst_cnt", 32'(o_sat_cnt), 0);
    q.delete();
    mcnt = 0;
    #2 rst_n = 1'b1;
    i_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      cyc(1);
      check("post_rst_valid", 32'(o_valid), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
